// File: rtl/seq_det_ctrl_if.sv
// rtl/seq_det_ctrl_if.sv - config, control, serial input and status bundle for seq_det_ctrl
// Signals:
//   cfg_we/cfg_seq/cfg_hits/cfg_timeout/cfg_overlap : run configuration, host side
//   start/abort                                     : run control
//   in/in_valid                                     : qualified serial bit
//   busy/hit/done/timeout/hit_cnt/state             : run status
// master = host + bit source, slave = seq_det_ctrl.
interface seq_det_ctrl_if #(
    parameter int SEQ_LEN = 7,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
);
    logic               cfg_we;
    logic [SEQ_LEN-1:0] cfg_seq;
    logic [CNT_W-1:0]   cfg_hits;
    logic [TO_W-1:0]    cfg_timeout;
    logic               cfg_overlap;
    logic               start;
    logic               abort;
    logic               in;
    logic               in_valid;
    logic               busy;
    logic               hit;
    logic               done;
    logic               timeout;
    logic [CNT_W-1:0]   hit_cnt;
    logic [2:0]         state;

    modport master (
        output cfg_we, cfg_seq, cfg_hits, cfg_timeout, cfg_overlap,
        output start, abort, in, in_valid,
        input  busy, hit, done, timeout, hit_cnt, state
    );

    modport slave (
        input  cfg_we, cfg_seq, cfg_hits, cfg_timeout, cfg_overlap,
        input  start, abort, in, in_valid,
        output busy, hit, done, timeout, hit_cnt, state
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - serial pattern detector run controller
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-low reset
//   bus   : seq_det_ctrl_if.slave (config, start/abort, serial bits, status)
// Arms a run on start, shifts qualified bits into a SEQ_LEN window, counts
// pattern hits (overlapping or refilling), and ends the run on the hit
// target (DONE), the cycle limit (TOUT) or abort (IDLE).
module seq_det_ctrl #(
    parameter int SEQ_LEN = 7,
    parameter int CNT_W   = 8,
    parameter int TO_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    seq_det_ctrl_if.slave bus
);
    localparam int FW = $clog2(SEQ_LEN + 1);
    localparam logic [FW:0]   LEN_W = (FW + 1)'(SEQ_LEN);
    localparam logic [FW-1:0] LEN_F = FW'(SEQ_LEN);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_TOUT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [SEQ_LEN-1:0] r_cfg_seq;
    logic [CNT_W-1:0]   r_cfg_hits;
    logic [TO_W-1:0]    r_cfg_timeout;
    logic               r_cfg_overlap;

    logic [SEQ_LEN-1:0] r_win;
    logic [FW-1:0]      r_fill;
    logic [TO_W-1:0]    r_timer;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic               r_hit;

    logic               w_busy;
    logic               w_start;
    logic               w_shift;
    logic [SEQ_LEN-1:0] w_new_win;
    logic [FW:0]        w_fill_inc;
    logic               w_full;
    logic [FW-1:0]      w_fill_nxt;
    logic               w_match;
    logic [CNT_W-1:0]   w_target;
    logic [CNT_W:0]     w_cnt_inc;
    logic               w_complete;
    logic               w_tout;

    assign w_busy     = (r_state == S_ARM) || (r_state == S_RUN);
    assign w_start    = bus.start && !w_busy;
    assign w_shift    = w_busy && bus.in_valid;
    assign w_new_win  = {r_win[SEQ_LEN-2:0], bus.in};
    assign w_fill_inc = {1'b0, r_fill} + (FW + 1)'(1);
    // The window only counts once the accepted bit completes it; this keeps
    // the cleared window from matching an all-zero pattern.
    assign w_full     = (w_fill_inc >= LEN_W);
    assign w_fill_nxt = w_full ? LEN_F : w_fill_inc[FW-1:0];
    assign w_match    = w_shift && w_full && (w_new_win == r_cfg_seq);
    assign w_target   = (r_cfg_hits == '0) ? CNT_W'(1) : r_cfg_hits;
    assign w_cnt_inc  = {1'b0, r_hit_cnt} + (CNT_W + 1)'(1);
    assign w_complete = w_match && (w_cnt_inc == {1'b0, w_target});
    assign w_tout     = w_busy && (r_cfg_timeout != '0) &&
                        (r_timer == r_cfg_timeout - TO_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: abort > completing hit > timeout > shift
    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TOUT: begin
                    if (bus.start) begin
                        w_next = S_ARM;
                    end
                end
                S_ARM, S_RUN: begin
                    if (w_complete) begin
                        w_next = S_DONE;
                    end else if (w_tout) begin
                        w_next = S_TOUT;
                    end else if (w_match && !r_cfg_overlap) begin
                        w_next = S_ARM;
                    end else if (w_shift && w_full) begin
                        w_next = S_RUN;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Config, window, timer and hit datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_seq     <= '0;
            r_cfg_hits    <= '0;
            r_cfg_timeout <= '0;
            r_cfg_overlap <= 1'b0;
            r_win         <= '0;
            r_fill        <= '0;
            r_timer       <= '0;
            r_hit_cnt     <= '0;
            r_hit         <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (bus.cfg_we && !w_busy) begin
                r_cfg_seq     <= bus.cfg_seq;
                r_cfg_hits    <= bus.cfg_hits;
                r_cfg_timeout <= bus.cfg_timeout;
                r_cfg_overlap <= bus.cfg_overlap;
            end
            // Abort leaves hit_cnt visible until the next start.
            if (!bus.abort) begin
                if (w_start) begin
                    r_win     <= '0;
                    r_fill    <= '0;
                    r_timer   <= '0;
                    r_hit_cnt <= '0;
                end else if (w_busy) begin
                    r_timer <= r_timer + TO_W'(1);
                    if (w_complete) begin
                        r_hit     <= 1'b1;
                        r_hit_cnt <= w_cnt_inc[CNT_W-1:0];
                    end else if (!w_tout && w_shift) begin
                        r_win  <= w_new_win;
                        r_fill <= w_fill_nxt;
                        if (w_match) begin
                            r_hit     <= 1'b1;
                            r_hit_cnt <= w_cnt_inc[CNT_W-1:0];
                            // Non-overlapping mode needs a full fresh window.
                            if (!r_cfg_overlap) begin
                                r_fill <= '0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Outputs
    always_comb begin
        bus.busy    = w_busy;
        bus.hit     = r_hit;
        bus.done    = (r_state == S_DONE);
        bus.timeout = (r_state == S_TOUT);
        bus.hit_cnt = r_hit_cnt;
        bus.state   = r_state;
    end
endmodule
